// File: rtl/iterative_left_shifter_if.sv
// rtl/iterative_left_shifter_if.sv - request/result handshake bundle for the iterative left shifter
interface iterative_left_shifter_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic               in_arith;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_ovf;

  modport master (
    output in_valid, in_data, in_shamt, in_arith, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_arith, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/iterative_left_shifter.sv
// rtl/iterative_left_shifter.sv - one-bit-per-clock left shifter with overflow flag and saturation
module iterative_left_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input logic                    clk,
  input logic                    rst,
  iterative_left_shifter_if.slave bus_io
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               arith_q, arith_d;
  logic               sign_q, sign_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   sat;
  logic               step_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      arith_q <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
    end
  end

  // Overflow is judged on the value before this cycle's shift.
  assign shifted  = {data_q[WIDTH-2:0], 1'b0};
  assign step_ovf = arith_q ? (data_q[WIDTH-1] ^ data_q[WIDTH-2]) : data_q[WIDTH-1];
  assign sat      = sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    arith_d = arith_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus_io.in_valid) begin
          data_d  = bus_io.in_data;
          cnt_d   = bus_io.in_shamt;
          arith_d = bus_io.in_arith;
          sign_d  = bus_io.in_data[WIDTH-1];
          ovf_d   = 1'b0;
          if (bus_io.in_shamt == '0) begin
            res_d   = bus_io.in_data;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = shifted;
        cnt_d  = cnt_q - 1'b1;
        ovf_d  = ovf_q | step_ovf;
        if (cnt_q == SHAMT_W'(1)) begin
          res_d   = (arith_q && ovf_d) ? sat : shifted;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus_io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.in_ready  = (state_q == IDLE);
  assign bus_io.out_valid = (state_q == DONE);
  assign bus_io.out_data  = res_q;
  assign bus_io.out_ovf   = ovf_q;
endmodule

// File: tb/tb_iterative_left_shifter.sv
// tb/tb_iterative_left_shifter.sv - randomized and directed checks against an arithmetic reference model
module tb_iterative_left_shifter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  iterative_left_shifter_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

  iterative_left_shifter #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact product, then range test: logical loses any bit above the word,
  // arithmetic must stay within the signed 8-bit range.
  function automatic void model(input logic [7:0] d, input int s, input logic a,
                                output logic [7:0] r, output logic o);
    longint full;
    if (!a) begin
      full = longint'(d) << s;
      r    = full[7:0];
      o    = (full >> 8) != 0;
    end else begin
      full = longint'($signed(d)) * (longint'(1) << s);
      o    = (full > 127) || (full < -128);
      r    = o ? (d[7] ? 8'h80 : 8'h7F) : full[7:0];
    end
  endfunction

  task automatic run_op(input logic [7:0] d, input logic [2:0] s, input logic a,
                        input int stall, input string tag);
    int         cyc;
    logic [7:0] ed;
    logic       eo;
    model(d, int'(s), a, ed, eo);
    bus.in_data   = d;
    bus.in_shamt  = s;
    bus.in_arith  = a;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    cyc = 1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, int'(s) + 1);
    check({tag, "_data"}, bus.out_data, ed);
    check({tag, "_ovf"}, bus.out_ovf, eo);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      bus.in_shamt = 3'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_v"}, bus.out_valid, 1'b1);
      check({tag, "_hold_rdy"}, bus.in_ready, 1'b0);
      check({tag, "_hold_data"}, bus.out_data, ed);
      check({tag, "_hold_ovf"}, bus.out_ovf, eo);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, "_post_v"}, bus.out_valid, 1'b0);
    check({tag, "_post_rdy"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_arith  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_out_ovf", bus.out_ovf, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'h06, 3'd1, 1'b0, 0, "log_06_1");
    run_op(8'h96, 3'd2, 1'b0, 0, "log_96_2");
    run_op(8'h01, 3'd7, 1'b0, 0, "log_01_7");
    run_op(8'hF9, 3'd1, 1'b1, 0, "ari_F9_1");
    run_op(8'hF9, 3'd5, 1'b1, 0, "ari_F9_5");
    run_op(8'h40, 3'd1, 1'b1, 0, "ari_40_1");
    run_op(8'hA5, 3'd0, 1'b0, 0, "zero_log");
    run_op(8'hA5, 3'd0, 1'b1, 0, "zero_ari");
    run_op(8'h81, 3'd3, 1'b0, 3, "bp_first");
    run_op(8'h3C, 3'd2, 1'b1, 0, "bp_next");

    // Abort a long operation with an asynchronous reset between edges.
    bus.in_data  = 8'hFF;
    bus.in_shamt = 3'd7;
    bus.in_arith = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_out_data", bus.out_data, 8'h00);
    check("abort_out_ovf", bus.out_ovf, 1'b0);
    check("abort_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(8'h05, 3'd2, 1'b0, 0, "after_rst");

    for (int k = 0; k < 40; k++) begin
      run_op(8'($urandom), 3'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
